// File: rtl/tx_fifo.sv
// tx_fifo: byte FIFO that feeds a serial transmitter through a tbr/en_tx load handshake.
// Defining TX_FIFO_OVF_EN adds a sticky overflow flag cleared by clr_ovf.
module tx_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   input  logic          tbr,
   output logic [7:0]    tx_data,
   output logic          en_tx,
   input  logic          clr_ovf,
   output logic          ovf
);

   typedef enum logic [1:0] {StIdle, StSend, StBusy, StDrain} state_e;

   localparam logic [AW:0] DepthCnt = DEPTH[AW:0];

   state_e        state_q, state_d;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          en_tx_q, en_tx_d;
   logic          wr_acc, pop;

   // Status comes only from the registered count, never from wr_en.
   assign full    = (count_q == DepthCnt);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign tx_data = tx_data_q;
   assign en_tx   = en_tx_q;

   assign wr_acc = wr_en && !full;
   assign pop    = (state_q == StSend);

   always_comb begin
      count_d = count_q;
      unique case ({wr_acc, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      en_tx_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!empty && tbr) begin
               tx_data_d = mem[rd_ptr_q];
               en_tx_d   = 1'b1;
               state_d   = StSend;
            end
         end
         StSend:  state_d = StBusy;
         StBusy:  if (!tbr) state_d = StDrain;
         StDrain: if (tbr) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Storage is intentionally not reset; stale bytes are unreachable once count is 0.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         tx_data_q <= 8'h00;
         en_tx_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         tx_data_q <= tx_data_d;
         en_tx_q   <= en_tx_d;
         if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

`ifdef TX_FIFO_OVF_EN
   logic ovf_q;

   // A dropped write takes priority over a simultaneous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_q <= 1'b0;
      end else if (wr_en && full) begin
         ovf_q <= 1'b1;
      end else if (clr_ovf) begin
         ovf_q <= 1'b0;
      end
   end

   assign ovf = ovf_q;
`else
   logic unused_clr_ovf;

   assign unused_clr_ovf = clr_ovf;
   assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_tx_fifo.sv
// tb_tx_fifo: directed self-checking bench for tx_fifo with a simple transmitter model on tbr.
module tb_tx_fifo;

   logic       clk, rst, wr_en, tbr, clr_ovf;
   logic [7:0] wr_data, tx_data;
   logic       full, empty, en_tx, ovf;
   logic [3:0] count;

   int         n_checks = 0;
   int         n_errors = 0;
   int         exp_cnt  = 0;
   logic       exp_ovf  = 1'b0;
   logic       prev_en  = 1'b0;
   logic       trk      = 1'b0;
   logic       xmit_on  = 1'b0;
   int         xmit_len = 0;
   int         xmit_cnt = 0;
   int         n_tx     = 0;
   logic [7:0] q [$];

   tx_fifo #(.DEPTH(8), .AW(3)) dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .full    (full),
      .empty   (empty),
      .count   (count),
      .tbr     (tbr),
      .tx_data (tx_data),
      .en_tx   (en_tx),
      .clr_ovf (clr_ovf),
      .ovf     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: update the reference model, then sample #1 after the edge.
   task automatic tick();
      logic acc, pop;
      acc = wr_en && (exp_cnt < 8);
      pop = en_tx;
`ifdef TX_FIFO_OVF_EN
      if (wr_en && exp_cnt == 8) exp_ovf = 1'b1;
      else if (clr_ovf)          exp_ovf = 1'b0;
`endif
      if (acc) q.push_back(wr_data);
      @(posedge clk);
      #1;
      if (pop) exp_cnt--;
      if (acc) exp_cnt++;
      if (trk) chk("count_track", count, exp_cnt);
      if (en_tx) begin
         chk("en_tx_gap", prev_en, 0);
         if (q.size() > 0) begin
            chk("tx_order", tx_data, q[0]);
            void'(q.pop_front());
         end else begin
            chk("tx_unexpected", en_tx, 0);
         end
         n_tx++;
         if (xmit_on) begin
            tbr      = 1'b0;
            xmit_cnt = xmit_len;
         end
      end else if (xmit_on && !tbr) begin
         xmit_cnt--;
         if (xmit_cnt <= 0) tbr = 1'b1;
      end
      prev_en = en_tx;
   endtask

   initial begin
      rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tbr = 1'b1; clr_ovf = 1'b0;
      #1;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_en_tx", en_tx, 0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_ovf", ovf, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      trk = 1'b1;

      // Single byte latency: en_tx two edges after the write.
      wr_en = 1'b1; wr_data = 8'hA5;
      tick();
      wr_en = 1'b0;
      chk("lat_e0_en_tx", en_tx, 0);
      chk("lat_e0_count", count, 1);
      tick();
      chk("lat_e1_en_tx", en_tx, 1);
      chk("lat_e1_tx_data", tx_data, 8'hA5);
      tick();
      chk("lat_e2_en_tx", en_tx, 0);
      chk("lat_e2_count", count, 0);
      chk("lat_e2_empty", empty, 1);
      chk("lat_hold_tx_data", tx_data, 8'hA5);

      // Fill with transmitter busy, then overflow.
      tbr = 1'b0;
      tick();
      for (int i = 1; i <= 8; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         tick();
      end
      chk("fill_full", full, 1);
      chk("fill_count", count, 8);
      wr_data = 8'hFF;
      tick();
      wr_en = 1'b0;
      chk("ovf_full", full, 1);
      chk("ovf_count", count, 8);
`ifdef TX_FIFO_OVF_EN
      chk("ovf_set", ovf, 1);
`else
      chk("ovf_set", ovf, 0);
`endif
      chk("ovf_model", ovf, exp_ovf);
      tick();
      chk("ovf_sticky", ovf, exp_ovf);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("ovf_clear", ovf, 0);

      // Drain through the transmitter model: 160 cycles low per byte.
      n_tx = 0; xmit_on = 1'b1; xmit_len = 160; tbr = 1'b1;
      for (int i = 0; i < 3000 && n_tx < 8; i++) tick();
      chk("drain_tx_count", n_tx, 8);
      repeat (170) tick();
      chk("drain_count", count, 0);
      chk("drain_empty", empty, 1);
      chk("drain_tx_data", tx_data, 8'h08);

      // Interleaved writes and drains across pointer wrap.
      n_tx = 0; xmit_len = 3;
      for (int i = 0; i < 12; i++) begin
         wr_en = 1'b1; wr_data = 8'h40 + 8'(i);
         tick();
         wr_en = 1'b0;
         tick();
         tick();
      end
      for (int i = 0; i < 300 && q.size() > 0; i++) tick();
      chk("wrap_tx_count", n_tx, 12);
      repeat (10) tick();
      chk("wrap_count", count, 0);
      chk("wrap_empty", empty, 1);

      // Reset while BUSY with three bytes queued.
      xmit_on = 1'b0; tbr = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_data = 8'hC0 + 8'(i);
         tick();
      end
      wr_en = 1'b0;
      repeat (4) tick();
      chk("pre_rst_count", count, 3);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_en_tx", en_tx, 0);
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_full", full, 0);
      chk("mid_rst_tx_data", tx_data, 8'h00);
      q.delete();
      exp_cnt = 0; prev_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      n_tx = 0;
      repeat (10) tick();
      chk("post_rst_no_tx", n_tx, 0);
      chk("post_rst_empty", empty, 1);
      wr_en = 1'b1; wr_data = 8'h5A;
      tick();
      wr_en = 1'b0;
      tick();
      chk("post_rst_en_tx", en_tx, 1);
      chk("post_rst_tx_data", tx_data, 8'h5A);
      tick();
      chk("post_rst_count", count, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
